// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, op, rs_val,
// rt_val in; out_valid/out_ready, result, flags {carry,neg,zero} out.
// Build macro: SEQ_ALU_MUL_EN adds the multi-cycle shift-and-add MUL.
module seq_alu #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    rs_val,
    input  logic [WIDTH-1:0]    rt_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic [2:0]          flags
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SSL = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(6);

    logic [1:0]       state;
    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] mul_res;
    logic             mul_carry;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] ssl_amt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] ld_res;
    logic             ld_carry;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    assign add_sum = {1'b0, rs_val} + {1'b0, rt_val};
    assign sub_sum = {1'b0, rs_val} + {1'b0, ~rt_val} + (WIDTH+1)'(1);

    // Magnitude of a negative shift count; shifts of WIDTH or more give 0.
    assign ssl_amt = rt_val[WIDTH-1] ? (~rt_val + 1'b1) : rt_val;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: {alu_carry, alu_res} = add_sum;
            OP_SUB: {alu_carry, alu_res} = sub_sum;
            OP_SSL: alu_res = rt_val[WIDTH-1] ? (rs_val >> ssl_amt)
                                              : (rs_val << ssl_amt);
            OP_SRA: alu_res = $unsigned($signed(rs_val) >>> rt_val[SW-1:0]);
            OP_AND: alu_res = rs_val & rt_val;
            OP_OR:  alu_res = rs_val | rt_val;
            OP_NOT: alu_res = ~rs_val;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(7);
    localparam logic [SW-1:0]       CNT_LAST = SW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;

    assign is_mul    = (op == OP_MUL);
    assign acc_nx    = mplier[0] ? (acc + mcand) : acc;
    assign mul_last  = (state == BUSY) && (cnt == CNT_LAST);
    assign mul_res   = acc_nx[WIDTH-1:0];
    assign mul_carry = |acc_nx[2*WIDTH-1:WIDTH];

    // One multiplier bit per BUSY cycle, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, rs_val};
            acc    <= '0;
            mplier <= rt_val;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign mul_last  = 1'b0;
    assign mul_res   = '0;
    assign mul_carry = 1'b0;
`endif

    assign ld_res   = (state == BUSY) ? mul_res   : alu_res;
    assign ld_carry = (state == BUSY) ? mul_carry : alu_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= BUSY;
                        end else begin
                            state  <= DONE;
                            result <= ld_res;
                            flags  <= {ld_carry, ld_res[WIDTH-1],
                                       ld_res == '0};
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (mul_last) begin
                        state  <= DONE;
                        result <= ld_res;
                        flags  <= {ld_carry, ld_res[WIDTH-1], ld_res == '0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
